// File: rtl/dmem_arbiter_if.sv
// Requester and RAM-side bus of the data-memory arbiter.
// The arbiter takes the slave view; the requesters/RAM side takes the master view.
interface dmem_arbiter_if;
    logic       _iCpuReq;
    logic       _iCpuWrite;
    logic [7:0] _iCpuAddr;
    logic [7:0] _iCpuWData;
    logic       _oCpuGnt;
    logic       _oCpuRValid;
    logic [7:0] _oCpuRData;

    logic       _iDbgReq;
    logic       _iDbgWrite;
    logic [7:0] _iDbgAddr;
    logic [7:0] _iDbgWData;
    logic       _oDbgGnt;
    logic       _oDbgRValid;
    logic [7:0] _oDbgRData;

    logic [7:0] _oMemAddr;
    logic [7:0] _oMemWData;
    logic       _oMemWrite;
    logic [7:0] _iMemRData;

    modport slave (
        input  _iCpuReq, _iCpuWrite, _iCpuAddr, _iCpuWData,
        output _oCpuGnt, _oCpuRValid, _oCpuRData,
        input  _iDbgReq, _iDbgWrite, _iDbgAddr, _iDbgWData,
        output _oDbgGnt, _oDbgRValid, _oDbgRData,
        output _oMemAddr, _oMemWData, _oMemWrite,
        input  _iMemRData
    );

    modport master (
        output _iCpuReq, _iCpuWrite, _iCpuAddr, _iCpuWData,
        input  _oCpuGnt, _oCpuRValid, _oCpuRData,
        output _iDbgReq, _iDbgWrite, _iDbgAddr, _iDbgWData,
        input  _oDbgGnt, _oDbgRValid, _oDbgRData,
        input  _oMemAddr, _oMemWData, _oMemWrite,
        output _iMemRData
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port 8-bit data RAM between the CPU and debug ports.
// Combinational grant, registered RAM lines, fixed 3-cycle read return.
module dmem_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic          _iClk,
    input  logic          _iReset,
    dmem_arbiter_if.slave bus
);
    logic       r_lastDbg;
    logic [1:0] r_vldPipe;
    logic [1:0] r_ownPipe;
    logic [7:0] r_memAddr;
    logic [7:0] r_memWData;
    logic       r_memWrite;
    logic       r_cpuRValid;
    logic       r_dbgRValid;
    logic [7:0] r_cpuRData;
    logic [7:0] r_dbgRData;

    logic       w_cpuGnt;
    logic       w_dbgGnt;
    logic       w_gnt;
    logic       w_write;
    logic [7:0] w_addr;
    logic [7:0] w_wdata;
    logic       w_retCpu;
    logic       w_retDbg;

    // CPU wins a contended cycle unless round-robin says Dbg is due.
    always_comb begin
        w_cpuGnt = _iReset & bus._iCpuReq & (!bus._iDbgReq | !FAIR | r_lastDbg);
        w_dbgGnt = _iReset & bus._iDbgReq & !w_cpuGnt;
        w_gnt    = w_cpuGnt | w_dbgGnt;
        w_write  = w_cpuGnt ? bus._iCpuWrite : bus._iDbgWrite;
        w_addr   = w_cpuGnt ? bus._iCpuAddr  : bus._iDbgAddr;
        w_wdata  = w_cpuGnt ? bus._iCpuWData : bus._iDbgWData;
        w_retCpu = r_vldPipe[1] & !r_ownPipe[1];
        w_retDbg = r_vldPipe[1] &  r_ownPipe[1];
    end

    always_ff @(posedge _iClk or negedge _iReset) begin
        if (!_iReset) begin
            r_lastDbg   <= 1'b1;
            r_vldPipe   <= '0;
            r_ownPipe   <= '0;
            r_memAddr   <= '0;
            r_memWData  <= '0;
            r_memWrite  <= 1'b0;
            r_cpuRValid <= 1'b0;
            r_dbgRValid <= 1'b0;
            r_cpuRData  <= '0;
            r_dbgRData  <= '0;
        end else begin
            if (w_gnt) begin
                r_lastDbg  <= w_dbgGnt;
                r_memAddr  <= w_addr;
                r_memWData <= w_wdata;
            end
            r_memWrite  <= w_gnt & w_write;
            // Stage 1 lines up with the cycle the RAM presents read data.
            r_vldPipe   <= {r_vldPipe[0], w_gnt & !w_write};
            r_ownPipe   <= {r_ownPipe[0], w_dbgGnt};
            r_cpuRValid <= w_retCpu;
            r_dbgRValid <= w_retDbg;
            if (w_retCpu) r_cpuRData <= bus._iMemRData;
            if (w_retDbg) r_dbgRData <= bus._iMemRData;
        end
    end

    assign bus._oCpuGnt    = w_cpuGnt;
    assign bus._oDbgGnt    = w_dbgGnt;
    assign bus._oCpuRValid = r_cpuRValid;
    assign bus._oDbgRValid = r_dbgRValid;
    assign bus._oCpuRData  = r_cpuRData;
    assign bus._oDbgRData  = r_dbgRData;
    assign bus._oMemAddr   = r_memAddr;
    assign bus._oMemWData  = r_memWData;
    assign bus._oMemWrite  = r_memWrite;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model plus a grant-order scoreboard on the
// round-robin instance, and directed checks on a fixed-priority instance.
module tb_dmem_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bA ();
    dmem_arbiter_if bB ();

    dmem_arbiter #(.FAIR(1'b1)) uA (._iClk(clk), ._iReset(rst_n), .bus(bA));
    dmem_arbiter #(.FAIR(1'b0)) uB (._iClk(clk), ._iReset(rst_n), .bus(bB));

    assign bB._iMemRData = 8'h00;

    int nVec = 0;
    int nErr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // RAM: write at the edge after the strobe, read data one cycle after address.
    logic [7:0] ram [256];
    bit         ramInit = 1'b0;
    always @(posedge clk) begin
        if (!ramInit && !rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            ram[1]  <= 8'h11;
            ram[2]  <= 8'h22;
            ramInit <= 1'b1;
        end else begin
            if (bA._oMemWrite) ram[bA._oMemAddr] <= bA._oMemWData;
            bA._iMemRData <= ram[bA._oMemAddr];
        end
    end

    // Reference memory is updated in grant order; reads push expected returns.
    typedef struct {
        logic       dbg;
        logic [7:0] data;
        int         cyc;
    } sb_t;
    sb_t        q [$];
    logic [7:0] refMem [256];
    bit         refInit = 1'b0;
    logic [7:0] expCpuRd = 8'h00;
    logic [7:0] expDbgRd = 8'h00;
    int         cyc = 0;

    always @(negedge clk) begin
        sb_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
            expCpuRd = 8'h00;
            expDbgRd = 8'h00;
            if (!refInit) begin
                for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
                refMem[1] = 8'h11;
                refMem[2] = 8'h22;
                refInit   = 1'b1;
            end
        end else begin
            if (bA._oCpuRValid || bA._oDbgRValid) begin
                chk("rv_onehot", {31'd0, bA._oCpuRValid & bA._oDbgRValid}, 0);
                if (q.size() == 0) chk("rv_unexpected", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rv_owner", {31'd0, bA._oDbgRValid}, {31'd0, e.dbg});
                    chk("rv_latency", cyc - e.cyc, 3);
                    if (e.dbg) expDbgRd = e.data;
                    else       expCpuRd = e.data;
                end
            end
            chk("gnt_onehot", {31'd0, bA._oCpuGnt & bA._oDbgGnt}, 0);
            if (bA._oCpuGnt) begin
                chk("cpu_gnt_req", {31'd0, bA._iCpuReq}, 1);
                if (bA._iCpuWrite) refMem[bA._iCpuAddr] = bA._iCpuWData;
                else q.push_back('{dbg: 1'b0, data: refMem[bA._iCpuAddr], cyc: cyc});
            end
            if (bA._oDbgGnt) begin
                chk("dbg_gnt_req", {31'd0, bA._iDbgReq}, 1);
                if (bA._iDbgWrite) refMem[bA._iDbgAddr] = bA._iDbgWData;
                else q.push_back('{dbg: 1'b1, data: refMem[bA._iDbgAddr], cyc: cyc});
            end
        end
        chk("cpu_rdata", {24'd0, bA._oCpuRData}, {24'd0, expCpuRd});
        chk("dbg_rdata", {24'd0, bA._oDbgRData}, {24'd0, expDbgRd});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpuDrv(input logic req, input logic wr, input logic [7:0] a, input logic [7:0] d);
        bA._iCpuReq = req; bA._iCpuWrite = wr; bA._iCpuAddr = a; bA._iCpuWData = d;
    endtask

    task automatic dbgDrv(input logic req, input logic wr, input logic [7:0] a, input logic [7:0] d);
        bA._iDbgReq = req; bA._iDbgWrite = wr; bA._iDbgAddr = a; bA._iDbgWData = d;
    endtask

    task automatic chkZeroA(input string tag);
        chk({tag, "_cgnt"},  {31'd0, bA._oCpuGnt}, 0);
        chk({tag, "_dgnt"},  {31'd0, bA._oDbgGnt}, 0);
        chk({tag, "_crv"},   {31'd0, bA._oCpuRValid}, 0);
        chk({tag, "_drv"},   {31'd0, bA._oDbgRValid}, 0);
        chk({tag, "_crd"},   {24'd0, bA._oCpuRData}, 0);
        chk({tag, "_drd"},   {24'd0, bA._oDbgRData}, 0);
        chk({tag, "_maddr"}, {24'd0, bA._oMemAddr}, 0);
        chk({tag, "_mwd"},   {24'd0, bA._oMemWData}, 0);
        chk({tag, "_mwr"},   {31'd0, bA._oMemWrite}, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cpuDrv(0, 0, 8'h00, 8'h00);
        dbgDrv(0, 0, 8'h00, 8'h00);
        bB._iCpuReq = 0; bB._iCpuWrite = 0; bB._iCpuAddr = 8'h01; bB._iCpuWData = 8'h00;
        bB._iDbgReq = 0; bB._iDbgWrite = 0; bB._iDbgAddr = 8'h02; bB._iDbgWData = 8'h00;
        #1 rst_n = 1'b0;
        #1 chkZeroA("rst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // CPU write 0x10 <- 0xA5
        cpuDrv(1, 1, 8'h10, 8'hA5);
        #1 chk("wr_gnt", {31'd0, bA._oCpuGnt}, 1);
        tick();
        cpuDrv(0, 0, 8'h00, 8'h00);
        chk("wr_addr",  {24'd0, bA._oMemAddr}, 32'h10);
        chk("wr_data",  {24'd0, bA._oMemWData}, 32'hA5);
        chk("wr_strb1", {31'd0, bA._oMemWrite}, 1);
        tick();
        chk("wr_strb0", {31'd0, bA._oMemWrite}, 0);

        // CPU read back 0x10
        cpuDrv(1, 0, 8'h10, 8'h00);
        #1 chk("rd_gnt", {31'd0, bA._oCpuGnt}, 1);
        tick();
        cpuDrv(0, 0, 8'h00, 8'h00);
        tick();
        chk("rd_rv_early", {31'd0, bA._oCpuRValid}, 0);
        tick();
        chk("rd_rv",   {31'd0, bA._oCpuRValid}, 1);
        chk("rd_data", {24'd0, bA._oCpuRData}, 32'hA5);
        chk("rd_dbg0", {24'd0, bA._oDbgRData}, 0);

        // Dbg write 0x20 <- 0x7F, CPU read right behind it, then a Dbg read
        dbgDrv(1, 1, 8'h20, 8'h7F);
        #1 chk("dw_gnt", {31'd0, bA._oDbgGnt}, 1);
        tick();
        dbgDrv(0, 0, 8'h00, 8'h00);
        cpuDrv(1, 0, 8'h20, 8'h00);
        #1 chk("raw_gnt", {31'd0, bA._oCpuGnt}, 1);
        tick();
        cpuDrv(0, 0, 8'h00, 8'h00);
        dbgDrv(1, 0, 8'h20, 8'h00);
        #1 chk("dr_gnt", {31'd0, bA._oDbgGnt}, 1);
        tick();
        dbgDrv(0, 0, 8'h00, 8'h00);
        repeat (4) tick();
        chk("raw_cpu", {24'd0, bA._oCpuRData}, 32'h7F);
        chk("raw_dbg", {24'd0, bA._oDbgRData}, 32'h7F);

        // Round-robin under continuous contention; last grant was Dbg
        cpuDrv(1, 0, 8'h01, 8'h00);
        dbgDrv(1, 0, 8'h02, 8'h00);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_cpu", {31'd0, bA._oCpuGnt}, (i % 2 == 0) ? 1 : 0);
            chk("rr_dbg", {31'd0, bA._oDbgGnt}, (i % 2 == 1) ? 1 : 0);
            tick();
        end
        cpuDrv(0, 0, 8'h00, 8'h00);
        dbgDrv(0, 0, 8'h00, 8'h00);
        repeat (6) tick();

        // Fixed priority: CPU starves Dbg until it lets go
        bB._iCpuReq = 1;
        bB._iDbgReq = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fp_cpu", {31'd0, bB._oCpuGnt}, 1);
            chk("fp_dbg", {31'd0, bB._oDbgGnt}, 0);
            tick();
        end
        bB._iCpuReq = 0;
        #1;
        chk("fp_dbg_rel", {31'd0, bB._oDbgGnt}, 1);
        chk("fp_cpu_rel", {31'd0, bB._oCpuGnt}, 0);
        tick();
        bB._iDbgReq = 0;
        tick();

        // Reset with a CPU read in flight and both ports requesting
        cpuDrv(1, 0, 8'h01, 8'h00);
        #1 chk("rs_gnt", {31'd0, bA._oCpuGnt}, 1);
        tick();
        rst_n = 1'b0;
        cpuDrv(1, 0, 8'h02, 8'h00);
        dbgDrv(1, 0, 8'h01, 8'h00);
        #1 chkZeroA("mid_rst");
        tick();
        rst_n = 1'b1;
        #1;
        chk("rs_cpu_first", {31'd0, bA._oCpuGnt}, 1);
        chk("rs_dbg_first", {31'd0, bA._oDbgGnt}, 0);
        tick();
        cpuDrv(0, 0, 8'h00, 8'h00);
        #1 chk("rs_dbg_next", {31'd0, bA._oDbgGnt}, 1);
        tick();
        dbgDrv(0, 0, 8'h00, 8'h00);
        repeat (8) tick();

        chk("sb_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
